seq_pattern_detect: RTL and testbench

Parametrised streaming character-sequence detector. It is the general successor to the fixed-phrase checker: the pattern is programmable, up to MAX_LEN symbols, and loaded through a write port. Overlapping and non-overlapping matching, case-insensitive comparison, a valid/ready input handshake, a registered echo stream and a saturating match counter are supported. It sits between the character source and the display/UART output path.

---
 rtl/seq_det_pkg.sv | 25 ++
 rtl/seq_pattern_ram.sv | 30 +++
 rtl/seq_pattern_detect.sv | 212 +++++++++++++++++++++
 tb/tb_seq_pattern_detect.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types, ASCII constants and the case-fold helper for the
// programmable sequence detector.
package seq_det_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [7:0] CH_A_UP  = 8'h41;
    localparam logic [7:0] CH_Z_UP  = 8'h5A;
    localparam logic [7:0] CASE_BIT = 8'h20;

    // Map ASCII upper-case letters onto lower case; everything else passes through.
    function automatic logic [7:0] fold(input logic [7:0] c);
        logic [7:0] r;
        if ((c >= CH_A_UP) && (c <= CH_Z_UP)) begin
            r = c | CASE_BIT;
        end else begin
            r = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_pattern_ram.sv
// Pattern register file: one write port, every entry visible in parallel
// so the comparators can look at the whole pattern in one cycle.
module seq_pattern_ram
    import seq_det_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16,
    localparam int AW     = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] mem_o [MAX_LEN]
);

    logic [DATA_W-1:0] mem_q [MAX_LEN];

    // Pattern storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (we_i && (addr_i == AW'(i))) begin
                mem_q[i] <= data_i;
            end
        end
    end

    assign mem_o = mem_q;

endmodule

// File: rtl/seq_pattern_detect.sv
// Streaming detector for a programmable symbol sequence with optional
// overlap, ASCII case folding, registered echo and saturating match counter.
module seq_pattern_detect
    import seq_det_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 16,
    localparam int AW     = $clog2(MAX_LEN),
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              case_ins,
    input  logic              overlap,
    input  logic              pat_wr_en,
    input  logic [AW-1:0]     pat_wr_addr,
    input  logic [DATA_W-1:0] pat_wr_data,
    input  logic [LW-1:0]     pat_len,
    output logic              pat_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              match,
    output logic [LW-1:0]     progress,
    output logic [CNT_W-1:0]  match_cnt,
    input  logic              clr_cnt
);

    state_e            state_q, state_d;
    logic [LW-1:0]     len_q, len_d, fill_q, fill_d, progress_q, progress_d;
    logic [DATA_W-1:0] hist_q [MAX_LEN];
    logic [DATA_W-1:0] hist_d [MAX_LEN];
    logic [DATA_W-1:0] hist_sh_s [MAX_LEN];
    logic [DATA_W-1:0] hist_f_s [MAX_LEN];
    logic [DATA_W-1:0] pat_s [MAX_LEN];
    logic [DATA_W-1:0] pat_f_s [MAX_LEN];
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d, match_q, match_d, pat_err_q, pat_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept_s, wr_ok_s, len_ok_s, all_eq_s, match_s;
    logic [LW-1:0]     fill_inc_s;
    logic [AW-1:0]     idx_s;

    assign wr_ok_s = pat_wr_en && (state_q == IDLE) && (int'(pat_wr_addr) < MAX_LEN);

    seq_pattern_ram #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN)
    ) u_ram (
        .clk    (clk),
        .we_i   (wr_ok_s),
        .addr_i (pat_wr_addr),
        .data_i (pat_wr_data),
        .mem_o  (pat_s)
    );

    // Candidate history with the incoming symbol shifted in at index 0.
    always_comb begin
        hist_sh_s[0] = in_data;
        for (int i = 1; i < MAX_LEN; i++) begin
            hist_sh_s[i] = hist_q[i-1];
        end
    end

    if (DATA_W == 8) begin : g_fold
        // Fold both sides of the comparison when case-insensitive matching is on.
        always_comb begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (case_ins) begin
                    hist_f_s[i] = fold(hist_sh_s[i]);
                    pat_f_s[i]  = fold(pat_s[i]);
                end else begin
                    hist_f_s[i] = hist_sh_s[i];
                    pat_f_s[i]  = pat_s[i];
                end
            end
        end
    end else begin : g_raw
        // Non-byte symbols are always compared exactly.
        always_comb begin
            for (int i = 0; i < MAX_LEN; i++) begin
                hist_f_s[i] = hist_sh_s[i];
                pat_f_s[i]  = pat_s[i];
            end
        end
    end

    // Newest symbol lines up with the last pattern symbol, oldest with the first.
    always_comb begin
        all_eq_s = 1'b1;
        idx_s    = {AW{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q)) begin
                idx_s = AW'(int'(len_q) - 1 - i);
                if (hist_f_s[i] != pat_f_s[idx_s]) begin
                    all_eq_s = 1'b0;
                end
            end
        end
    end

    assign accept_s   = in_valid && (state_q == RUN);
    assign len_ok_s   = (len_q != {LW{1'b0}}) && (int'(len_q) <= MAX_LEN);
    assign fill_inc_s = (fill_q >= len_q) ? len_q : (fill_q + LW'(1));
    assign match_s    = accept_s && enable && len_ok_s && (fill_inc_s == len_q) && all_eq_s;

    // Next-state, history, echo and counter logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        fill_d      = fill_q;
        hist_d      = hist_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        match_d     = 1'b0;
        progress_d  = progress_q;
        pat_err_d   = pat_wr_en && !wr_ok_s;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    len_d   = pat_len;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Abandon any partial match; a beat on this edge is echoed only.
                    state_d    = IDLE;
                    fill_d     = {LW{1'b0}};
                    progress_d = {LW{1'b0}};
                    for (int i = 0; i < MAX_LEN; i++) begin
                        hist_d[i] = {DATA_W{1'b0}};
                    end
                    if (accept_s) begin
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else if (accept_s) begin
                    hist_d      = hist_sh_s;
                    fill_d      = (match_s && !overlap) ? {LW{1'b0}} : fill_inc_s;
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    match_d     = match_s;
                    progress_d  = fill_inc_s;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr_cnt) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (match_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, history and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= {LW{1'b0}};
            fill_q      <= {LW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            match_q     <= 1'b0;
            progress_q  <= {LW{1'b0}};
            pat_err_q   <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            for (int i = 0; i < MAX_LEN; i++) begin
                hist_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            match_q     <= match_d;
            progress_q  <= progress_d;
            pat_err_q   <= pat_err_d;
            cnt_q       <= cnt_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign in_ready  = (state_q == RUN);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign match     = match_q;
    assign progress  = progress_q;
    assign match_cnt = cnt_q;
    assign pat_err   = pat_err_q;

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Scoreboard bench for seq_pattern_detect: directed streams push expected
// echoes into a queue, a negedge monitor pops and compares them.
module tb_seq_pattern_detect;

    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 12;
    localparam int CNT_W   = 4;
    localparam int AW      = $clog2(MAX_LEN);
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0, case_ins = 1'b0, overlap = 1'b0;
    logic              pat_wr_en = 1'b0;
    logic [AW-1:0]     pat_wr_addr = '0;
    logic [DATA_W-1:0] pat_wr_data = '0;
    logic [LW-1:0]     pat_len = '0;
    logic              pat_err;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              match;
    logic [LW-1:0]     progress;
    logic [CNT_W-1:0]  match_cnt;
    logic              clr_cnt = 1'b0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              m;
        logic [LW-1:0]     p;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    seq_pattern_detect #(
        .DATA_W  (DATA_W),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .case_ins    (case_ins),
        .overlap     (overlap),
        .pat_wr_en   (pat_wr_en),
        .pat_wr_addr (pat_wr_addr),
        .pat_wr_data (pat_wr_data),
        .pat_len     (pat_len),
        .pat_err     (pat_err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .match       (match),
        .progress    (progress),
        .match_cnt   (match_cnt),
        .clr_cnt     (clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every echoed beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_echo: got data %0h with no beat pending", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("echo_data", 32'(out_data), 32'(e.d));
                    chk("echo_match", 32'(match), 32'(e.m));
                    chk("echo_progress", 32'(progress), 32'(e.p));
                end
            end else if (match) begin
                checks++;
                errors++;
                $display("FAIL stray_match: got match=1 expected 0 without out_valid");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic m, input int p);
        exp_t e;
        e.d = c;
        e.m = m;
        e.p = LW'(p);
        sb.push_back(e);
        in_valid = 1'b1;
        in_data  = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load(input string s);
        for (int i = 0; i < s.len(); i++) begin
            pat_wr_en   = 1'b1;
            pat_wr_addr = AW'(i);
            pat_wr_data = s[i];
            tick();
        end
        pat_wr_en = 1'b0;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        tick();
    endtask

    task automatic go_run(input int len);
        pat_len = LW'(len);
        enable  = 1'b1;
        tick();
    endtask

    task automatic clr();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    initial begin
        #22;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_progress", 32'(progress), 32'd0);
        chk("rst_match_cnt", 32'(match_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_pat_err", 32'(pat_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // "love" found inside "ilove"
        load("love");
        chk("load_no_err", 32'(pat_err), 32'd0);
        go_run(4);
        chk("run_in_ready", 32'(in_ready), 32'd1);
        send("i", 1'b0, 1);
        send("l", 1'b0, 2);
        send("o", 1'b0, 3);
        send("v", 1'b0, 4);
        send("e", 1'b1, 4);
        tick();
        chk("love_cnt", 32'(match_cnt), 32'd1);

        // "aa" with and without overlap
        go_idle();
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        clr();
        chk("clr_cnt", 32'(match_cnt), 32'd0);
        load("aa");
        overlap = 1'b1;
        go_run(2);
        send("a", 1'b0, 1);
        send("a", 1'b1, 2);
        send("a", 1'b1, 2);
        send("a", 1'b1, 2);
        tick();
        chk("aa_ovl_cnt", 32'(match_cnt), 32'd3);
        go_idle();
        clr();
        overlap = 1'b0;
        go_run(2);
        send("a", 1'b0, 1);
        send("a", 1'b1, 2);
        send("a", 1'b0, 1);
        send("a", 1'b1, 2);
        tick();
        chk("aa_novl_cnt", 32'(match_cnt), 32'd2);

        // case folding
        go_idle();
        clr();
        load("You");
        case_ins = 1'b1;
        go_run(3);
        send("y", 1'b0, 1);
        send("O", 1'b0, 2);
        send("U", 1'b1, 3);
        go_idle();
        case_ins = 1'b0;
        go_run(3);
        send("y", 1'b0, 1);
        send("O", 1'b0, 2);
        send("U", 1'b0, 3);
        tick();
        chk("case_cnt", 32'(match_cnt), 32'd1);

        // abandoned partial match and dropped beats while idle
        go_idle();
        clr();
        load("love");
        go_run(4);
        send("l", 1'b0, 1);
        send("o", 1'b0, 2);
        send("v", 1'b0, 3);
        go_idle();
        in_valid = 1'b1;
        in_data  = "e";
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        go_run(4);
        send("e", 1'b0, 1);
        tick();
        chk("abandon_cnt", 32'(match_cnt), 32'd0);

        // rejected pattern writes leave the pattern intact
        pat_wr_en   = 1'b1;
        pat_wr_addr = '0;
        pat_wr_data = "x";
        tick();
        pat_wr_en = 1'b0;
        chk("err_run_write", 32'(pat_err), 32'd1);
        tick();
        chk("err_pulse_end", 32'(pat_err), 32'd0);
        go_idle();
        pat_wr_en   = 1'b1;
        pat_wr_addr = AW'(MAX_LEN);
        pat_wr_data = "x";
        tick();
        pat_wr_en = 1'b0;
        chk("err_addr_range", 32'(pat_err), 32'd1);
        go_run(4);
        send("l", 1'b0, 1);
        send("o", 1'b0, 2);
        send("v", 1'b0, 3);
        send("e", 1'b1, 4);
        tick();
        chk("ram_kept_cnt", 32'(match_cnt), 32'd1);

        // zero and oversized lengths never match
        go_idle();
        go_run(0);
        send("l", 1'b0, 0);
        send("o", 1'b0, 0);
        send("v", 1'b0, 0);
        send("e", 1'b0, 0);
        go_idle();
        go_run(MAX_LEN + 1);
        send("l", 1'b0, 1);
        send("o", 1'b0, 2);
        send("v", 1'b0, 3);
        send("e", 1'b0, 4);
        tick();
        chk("badlen_cnt", 32'(match_cnt), 32'd1);

        // counter saturation and clear priority
        go_idle();
        clr();
        overlap = 1'b1;
        go_run(1);
        for (int i = 0; i < 17; i++) begin
            send("l", 1'b1, 1);
        end
        tick();
        chk("sat_cnt", 32'(match_cnt), 32'hF);
        clr_cnt = 1'b1;
        send("l", 1'b1, 1);
        clr_cnt = 1'b0;
        chk("clr_wins", 32'(match_cnt), 32'd0);
        send("l", 1'b1, 1);
        chk("after_clr", 32'(match_cnt), 32'd1);

        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
